trng_health_monitor: RTL and testbench
======================================

# trng_health_monitor

Online health-test stage that sits directly downstream of the coherent sampler and alongside the matching controller. It observes the sampler's `CSReq`/`CSCnt` handshake without driving `CSAck`, extracts the random LSBs of each accepted counter value, and runs a repetition count test (RCT) and an adaptive proportion test (APT) on bit 0, in the style of SP 800-90B. It emits validated random bits to the transmit path and raises sticky alarms.

## Interface
Parameters:
- `CSCntWidth`, 16, coherent sampler counter width.
- `NBLSB`, 1, LSBs of `CSCnt` forwarded as random data (1..8).
- `RCTCutoff`, 21, consecutive-identical-bit count that fails the RCT (2..255).
- `APTWindowLog`, 9, APT window length = 2^`APTWindowLog` samples.
- `APTCutoff`, 410, matching-bit count within one window that fails the APT (≤ window length).

Ports:
- `clk`  in  1  system clock (125 MHz).
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `CSCnt`  in  `CSCntWidth`  sampler counter; stable while `CSReq` is high.
- `CSReq`  in  1  sampler request, asynchronous to `clk`; observe only.
- `matched`  in  1  matching controller has locked a configuration; tests run only while high.
- `clearAlarm`  in  1  single-cycle pulse that clears sticky failures.
- `randBits`  out  `NBLSB`  captured random LSBs.
- `randValid`  out  1  one-cycle strobe qualifying `randBits`.
- `rctFail`  out  1  sticky RCT failure.
- `aptFail`  out  1  sticky APT failure.
- `alarm`  out  1  `rctFail | aptFail`, registered.

## Operation
- `CSReq` passes through a 2-flop synchronizer plus an edge register. A synchronized rising edge produces `capture` and latches `CSCnt` into `sample`. No capture occurs on the falling edge.
- `capture` while `matched`=0 is ignored. In that case `randValid` stays 0 and no test state changes.
- `matched` low for any cycle resets the RCT and APT state to `IDLE` but leaves the sticky flags unchanged.
- RCT states: `IDLE` then `RUN`.
  - First accepted sample: `lastBit`=bit, `rctCnt`=1, go to `RUN`.
  - In `RUN`, equal bit: `rctCnt`+1, saturating at 255. Different bit: `lastBit`=bit, `rctCnt`=1.
  - When `rctCnt` reaches `RCTCutoff`, set `rctFail`.
- APT states: `IDLE` then `RUN`.
  - First sample of a window: `refBit`=bit, `aptMatch`=1, `aptIdx`=1.
  - Each later sample: `aptIdx`+1, and `aptMatch`+1 if bit == `refBit`.
  - When `aptMatch` reaches `APTCutoff`, set `aptFail`.
  - When `aptIdx` reaches 2^`APTWindowLog`, the next sample starts a new window. Windows do not overlap.
- `randValid` pulses for every accepted sample while `alarm`=0. `randBits`=`sample[NBLSB-1:0]`. A sample that causes a failure is itself suppressed.
- Sticky flags are cleared by `rst` or `clearAlarm`. If `clearAlarm` and a new failure land in the same cycle, the failure wins.
- Counter widths: `rctCnt` is 8 bits. `aptIdx` and `aptMatch` are `APTWindowLog`+1 bits.

## Timing
- Reset values: all outputs 0, tests in `IDLE`, synchronizer flops 0.
- `capture` asserts 3 `clk` cycles after `CSReq` rises, counting 2 sync cycles plus 1 edge cycle. The latched `CSCnt` is sampled in that same cycle.
- `randBits`, `randValid`, and the updated test counters appear 1 cycle after `capture`.
- `rctFail`/`aptFail` assert in that same cycle. `alarm` follows 1 cycle later.
- `CSReq` must stay high for at least 3 `clk` cycles to be seen. The matching controller's handshake guarantees this.
- An asynchronous `rst` assertion mid-sample discards the in-flight capture. The first sample after reset release starts fresh windows.

## Structure
- Package `trng_health_pkg`: default cutoff constants, the `IDLE`/`RUN` state typedef, and the counter-width function `clog2`.
- Sub-module `req_sync_edge`: 2-flop synchronizer plus rising-edge pulse, reusable for any sampler-domain strobe.
- RCT and APT stay inline in the top-level block; each is a small always block.

## Test plan
- Alternating bits 0,1,0,1… for 1000 samples with `matched`=1 → 1000 `randValid` pulses, `rctFail`=`aptFail`=0.
- 21 consecutive samples with bit 0 = 1 → `rctFail` set on the 21st capture +1 cycle, 20 `randValid` pulses, `alarm` one cycle later. `clearAlarm` → all flags 0.
- Window of 512 samples, first 410 equal to `refBit` → `aptFail` on the 410th sample. With 409 matches, no fail and the next window starts at sample 513.
- `matched` dropped after 15 identical bits, then raised with 15 more identical bits → no `rctFail` (counter restarted).
- `CSReq` pulse of 2 `clk` cycles → no capture. A pulse of 3 cycles → exactly one capture, with `randValid` at edge +4 cycles.
- `rst` asserted 1 cycle after `capture` → all outputs 0 immediately, with no `randValid` for that sample.

Source files
------------

// File: rtl/trng_health_pkg.sv
// trng_health_pkg: shared constants, test state type and width helper for the TRNG health monitor
package trng_health_pkg;
  localparam int RCT_CUTOFF_DEF     = 21;
  localparam int APT_WINDOW_LOG_DEF = 9;
  localparam int APT_CUTOFF_DEF     = 410;
  localparam int RCT_CNT_MAX        = 255;
  typedef enum logic {IDLE, RUN} test_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = v - 1; i > 0; i = i >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/req_sync_edge.sv
// req_sync_edge: synchronizes an async strobe and emits a one-cycle pulse on a qualified rising edge
// Ports: clk, rst (async, active-high), d_async (foreign-domain strobe), pulse (one cycle, clk domain)
module req_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic pulse
);
  logic [1:0] sync_q, sync_d, hist_q, hist_d;
  always_comb begin
    sync_d = {sync_q[0], d_async};
    hist_d = {hist_q[0], sync_q[1]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end
  // Three consecutive high samples after a low one: strobes shorter than three
  // cycles never fire, and a legal strobe fires exactly three cycles after it rises.
  assign pulse = sync_q[0] & sync_q[1] & hist_q[0] & ~hist_q[1];
endmodule

// File: rtl/trng_health_monitor.sv
// trng_health_monitor: captures sampler LSBs, runs repetition-count and adaptive-proportion tests, raises sticky alarms
// Ports: clk, rst (async, active-high); CSCnt/CSReq observed sampler handshake; matched enables the tests;
//        clearAlarm clears sticky flags; randBits/randValid validated random data; rctFail/aptFail/alarm failures
module trng_health_monitor
  import trng_health_pkg::*;
#(
  parameter int CSCntWidth   = 16,
  parameter int NBLSB        = 1,
  parameter int RCTCutoff    = RCT_CUTOFF_DEF,
  parameter int APTWindowLog = APT_WINDOW_LOG_DEF,
  parameter int APTCutoff    = APT_CUTOFF_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CSCntWidth-1:0] CSCnt,
  input  logic                  CSReq,
  input  logic                  matched,
  input  logic                  clearAlarm,
  output logic [NBLSB-1:0]      randBits,
  output logic                  randValid,
  output logic                  rctFail,
  output logic                  aptFail,
  output logic                  alarm
);
  localparam int AW = APTWindowLog + 1;
  localparam int RW = clog2(RCT_CNT_MAX + 1);
  logic capture, accept, bit0, rct_same, rct_hit, apt_new, apt_inc, apt_hit;
  test_state_e rct_state_q, rct_state_d, apt_state_q, apt_state_d;
  logic last_bit_q, last_bit_d, ref_bit_q, ref_bit_d;
  logic [RW-1:0] rct_cnt_q, rct_cnt_d;
  logic [AW-1:0] apt_idx_q, apt_idx_d, apt_match_q, apt_match_d;
  logic [NBLSB-1:0] rand_bits_q, rand_bits_d;
  logic rand_valid_q, rand_valid_d, rct_fail_q, rct_fail_d, apt_fail_q, apt_fail_d, alarm_q, alarm_d;
  logic unused_cnt;
  req_sync_edge u_sync (.clk(clk), .rst(rst), .d_async(CSReq), .pulse(capture));
  // CSCnt is stable while CSReq is high, so it is read directly in the capture cycle.
  assign accept     = capture & matched;
  assign bit0       = CSCnt[0];
  assign unused_cnt = ^CSCnt[CSCntWidth-1:NBLSB];
  always_comb begin
    rct_same    = rct_state_q == RUN && bit0 == last_bit_q;
    rct_state_d = !matched ? IDLE : accept ? RUN : rct_state_q;
    last_bit_d  = accept ? bit0 : last_bit_q;
    rct_cnt_d   = !matched ? '0 : !accept ? rct_cnt_q : !rct_same ? RW'(1) :
                  rct_cnt_q == RW'(RCT_CNT_MAX) ? rct_cnt_q : rct_cnt_q + 1'b1;
    rct_hit     = accept && rct_cnt_d == RW'(RCTCutoff);
  end
  always_comb begin
    apt_new     = apt_state_q == IDLE || apt_idx_q == AW'(1 << APTWindowLog);
    apt_inc     = apt_new || bit0 == ref_bit_q;
    apt_state_d = !matched ? IDLE : accept ? RUN : apt_state_q;
    ref_bit_d   = accept && apt_new ? bit0 : ref_bit_q;
    apt_idx_d   = !matched ? '0 : !accept ? apt_idx_q : apt_new ? AW'(1) : apt_idx_q + 1'b1;
    apt_match_d = !matched ? '0 : !accept ? apt_match_q : apt_new ? AW'(1) : apt_match_q + AW'(apt_inc);
    apt_hit     = accept && apt_inc && apt_match_d == AW'(APTCutoff);
  end
  // A new failure outranks a simultaneous clear; the failing sample itself is withheld.
  always_comb begin
    rct_fail_d   = rct_hit || (rct_fail_q && !clearAlarm);
    apt_fail_d   = apt_hit || (apt_fail_q && !clearAlarm);
    alarm_d      = rct_fail_q | apt_fail_q;
    rand_valid_d = accept && !alarm_q && !rct_fail_q && !apt_fail_q && !rct_hit && !apt_hit;
    rand_bits_d  = accept ? CSCnt[NBLSB-1:0] : rand_bits_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rct_state_q  <= IDLE;
      apt_state_q  <= IDLE;
      last_bit_q   <= 1'b0;
      ref_bit_q    <= 1'b0;
      rct_cnt_q    <= '0;
      apt_idx_q    <= '0;
      apt_match_q  <= '0;
      rand_bits_q  <= '0;
      rand_valid_q <= 1'b0;
      rct_fail_q   <= 1'b0;
      apt_fail_q   <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      rct_state_q  <= rct_state_d;
      apt_state_q  <= apt_state_d;
      last_bit_q   <= last_bit_d;
      ref_bit_q    <= ref_bit_d;
      rct_cnt_q    <= rct_cnt_d;
      apt_idx_q    <= apt_idx_d;
      apt_match_q  <= apt_match_d;
      rand_bits_q  <= rand_bits_d;
      rand_valid_q <= rand_valid_d;
      rct_fail_q   <= rct_fail_d;
      apt_fail_q   <= apt_fail_d;
      alarm_q      <= alarm_d;
    end
  end
  assign randBits  = rand_bits_q;
  assign randValid = rand_valid_q;
  assign rctFail   = rct_fail_q;
  assign aptFail   = apt_fail_q;
  assign alarm     = alarm_q;
endmodule

// File: tb/tb_trng_health_monitor.sv
// tb_trng_health_monitor: directed self-checking bench for trng_health_monitor
module tb_trng_health_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] CSCnt = '0;
  logic CSReq = 1'b0;
  logic matched = 1'b0;
  logic clearAlarm = 1'b0;
  logic [0:0] randBits;
  logic randValid, rctFail, aptFail, alarm;
  int n_assert = 0;
  int n_fail = 0;
  int vcnt = 0;
  int base;
  trng_health_monitor dut (
    .clk(clk), .rst(rst), .CSCnt(CSCnt), .CSReq(CSReq), .matched(matched),
    .clearAlarm(clearAlarm), .randBits(randBits), .randValid(randValid),
    .rctFail(rctFail), .aptFail(aptFail), .alarm(alarm)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (randValid === 1'b1) vcnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic b);
    @(negedge clk);
    CSCnt = (16'($urandom) & 16'hFFFE) | 16'(b);
    CSReq = 1'b1;
    repeat (3) @(negedge clk);
    CSReq = 1'b0;
  endtask
  task automatic drop();
    @(negedge clk);
    matched = 1'b0;
    @(negedge clk);
    matched = 1'b1;
  endtask
  task automatic settle();
    @(negedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_randValid", 32'(randValid), 0);
    chk("reset_flags", {29'd0, rctFail, aptFail, alarm}, 0);
    chk("reset_randBits", 32'(randBits), 0);
    rst = 1'b0;
    // capture ignored while unmatched
    base = vcnt;
    send(1'b1);
    settle();
    chk("unmatched_no_valid", 32'(vcnt - base), 0);
    // 3-cycle pulse: capture after edge 3, randValid after edge 4 only
    matched = 1'b1;
    @(negedge clk);
    CSCnt = 16'h00A1;
    CSReq = 1'b1;
    repeat (3) @(negedge clk);
    CSReq = 1'b0;
    #1;
    chk("pulse3_not_yet", 32'(randValid), 0);
    settle();
    chk("pulse3_valid", 32'(randValid), 1);
    chk("pulse3_bits", 32'(randBits), 1);
    settle();
    chk("pulse3_one_shot", 32'(randValid), 0);
    // 2-cycle pulse is never seen
    base = vcnt;
    @(negedge clk);
    CSReq = 1'b1;
    repeat (2) @(negedge clk);
    CSReq = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("pulse2_no_capture", 32'(vcnt - base), 0);
    // alternating bits pass both tests
    drop();
    base = vcnt;
    for (int i = 0; i < 1000; i++) send(1'(i));
    settle();
    chk("alt_valid_count", 32'(vcnt - base), 1000);
    chk("alt_no_fail", {30'd0, rctFail, aptFail}, 0);
    // matched drop restarts the repetition count
    drop();
    base = vcnt;
    for (int i = 0; i < 15; i++) send(1'b1);
    drop();
    for (int i = 0; i < 15; i++) send(1'b1);
    settle();
    chk("matched_drop_no_rct", 32'(rctFail), 0);
    chk("matched_drop_count", 32'(vcnt - base), 30);
    // 21 identical bits trip the RCT
    drop();
    base = vcnt;
    for (int i = 0; i < 20; i++) send(1'b1);
    settle();
    chk("rct_20_no_fail", 32'(rctFail), 0);
    send(1'b1);
    settle();
    chk("rct_21_fail", 32'(rctFail), 1);
    chk("rct_21_suppressed", 32'(randValid), 0);
    chk("rct_alarm_lag", 32'(alarm), 0);
    chk("rct_valid_count", 32'(vcnt - base), 20);
    settle();
    chk("rct_alarm", 32'(alarm), 1);
    clearAlarm = 1'b1;
    @(negedge clk);
    clearAlarm = 1'b0;
    settle();
    chk("clear_flags", {29'd0, rctFail, aptFail, alarm}, 0);
    // window with 409 matches passes; sample 513 opens a fresh window
    drop();
    base = vcnt;
    for (int g = 0; g < 102; g++) begin
      for (int k = 0; k < 4; k++) send(1'b0);
      send(1'b1);
    end
    send(1'b0);
    send(1'b1);
    settle();
    chk("apt_409_no_fail", 32'(aptFail), 0);
    send(1'b0);
    settle();
    chk("apt_513_new_window", 32'(aptFail), 0);
    chk("apt_409_count", 32'(vcnt - base), 513);
    // window with 410 matches fails on the 410th match (sample 512)
    drop();
    base = vcnt;
    for (int g = 0; g < 102; g++) begin
      for (int k = 0; k < 4; k++) send(1'b0);
      send(1'b1);
    end
    send(1'b0);
    settle();
    chk("apt_511_no_fail", 32'(aptFail), 0);
    send(1'b0);
    settle();
    chk("apt_410_fail", 32'(aptFail), 1);
    chk("apt_410_suppressed", 32'(randValid), 0);
    chk("apt_410_count", 32'(vcnt - base), 511);
    settle();
    chk("apt_alarm", 32'(alarm), 1);
    // reset in the capture cycle discards the sample and clears everything
    base = vcnt;
    @(negedge clk);
    CSCnt = 16'h0001;
    CSReq = 1'b1;
    repeat (3) @(negedge clk);
    CSReq = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_flags", {29'd0, rctFail, aptFail, alarm}, 0);
    chk("rst_randValid", 32'(randValid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_discard", 32'(vcnt - base), 0);
    send(1'b1);
    settle();
    chk("post_rst_sample", 32'(randValid), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: observed no end, expected end before 2000000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
